// File: rtl/irq_trigger_gen.sv
// irq_trigger_gen: multi-channel interrupt stimulus generator.
//
// Each channel watches the CPU macroscopic PC. When it reaches the programmed
// trigger address, the channel raises its irq line. In ACK mode the line stays
// high until the handler stores to the channel's ack word. In PULSE mode it stays
// high for PULSE_LEN cycles. A HOLDOFF period follows, and then the channel either
// re-arms or goes idle once its programmed fire count is used up.
//
// Ports:
//   clk            system clock, all state on posedge
//   reset          asynchronous active-high reset
//   macroscopic_pc CPU macroscopic PC (bits [1:0] ignored)
//   m_data_addr    M-stage data address (bits [1:0] ignored)
//   m_data_byteen  store byte enables, nonzero = store this cycle
//   cfg_we         program channel cfg_ch this cycle
//   cfg_ch         channel select (values >= NUM_CH ignored)
//   cfg_pc         trigger PC (bits [1:0] ignored)
//   cfg_mode       0 = ACK mode, 1 = PULSE mode
//   cfg_count      fires allowed, 0 = unlimited
//   irq            registered per-channel interrupt lines
//   interrupt      OR of irq
//   fired_total    saturating count of all fires
module irq_trigger_gen #(
  parameter int unsigned NUM_CH    = 4,
  parameter logic [31:0] ACK_BASE  = 32'h7F20,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned HOLDOFF   = 4,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_data_addr,
  input  logic [3:0]        m_data_byteen,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [31:0]       cfg_pc,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [NUM_CH-1:0] irq,
  output logic              interrupt,
  output logic [CNT_W-1:0]  fired_total
);

  typedef enum logic [1:0] {StIdle, StArmed, StAsserted, StHoldoff} ch_state_e;

  localparam int unsigned TMR_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLDOFF - 1);
  // Enough headroom to add up to eight simultaneous fires before saturating.
  localparam int unsigned SUM_W = CNT_W + 4;

  logic [NUM_CH-1:0] fire;
  logic              store;

  // Low address bits are don't-care everywhere.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{macroscopic_pc[1:0], m_data_addr[1:0], cfg_pc[1:0]};

  assign store = |m_data_byteen;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    localparam logic [31:0] AckAddr = ACK_BASE + 32'(4 * g);

    ch_state_e        state_q, state_d;
    logic [29:0]      pc_q, pc_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] fires_q, fires_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    // Set once the PC has been off the trigger since the last fire; gates re-firing.
    logic             left_q, left_d;
    logic             irq_q, irq_d;
    logic             sel, pc_hit, ack_hit, fire_ch;

    assign sel     = cfg_we && (32'(cfg_ch) == 32'(g));
    assign pc_hit  = (macroscopic_pc[31:2] == pc_q);
    assign ack_hit = store && (AckAddr[1:0] == 2'b00) && (m_data_addr[31:2] == AckAddr[31:2]);

    always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mode_d  = mode_q;
      count_d = count_q;
      fires_d = fires_q;
      tmr_d   = tmr_q;
      left_d  = left_q | ~pc_hit;
      fire_ch = 1'b0;
      if (sel) begin
        pc_d    = cfg_pc[31:2];
        mode_d  = cfg_mode;
        count_d = cfg_count;
        fires_d = '0;
        tmr_d   = '0;
        left_d  = 1'b1;
        state_d = StArmed;
      end else begin
        unique case (state_q)
          StIdle: ;
          StArmed: begin
            if (pc_hit && left_q) begin
              state_d = StAsserted;
              fire_ch = 1'b1;
              left_d  = 1'b0;
              tmr_d   = PULSE_LOAD;
              if (fires_q != {CNT_W{1'b1}}) fires_d = fires_q + 1'b1;
            end
          end
          StAsserted: begin
            if (mode_q) begin
              if (tmr_q == '0) begin
                state_d = StHoldoff;
                tmr_d   = HOLD_LOAD;
              end else begin
                tmr_d = tmr_q - 1'b1;
              end
            end else if (ack_hit) begin
              state_d = StHoldoff;
              tmr_d   = HOLD_LOAD;
            end
          end
          StHoldoff: begin
            if (tmr_q == '0) begin
              if ((count_q != '0) && (fires_q == count_q)) state_d = StIdle;
              else                                         state_d = StArmed;
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
      irq_d = (state_d == StAsserted);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        pc_q    <= '0;
        mode_q  <= 1'b0;
        count_q <= '0;
        fires_q <= '0;
        tmr_q   <= '0;
        left_q  <= 1'b0;
        irq_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        pc_q    <= pc_d;
        mode_q  <= mode_d;
        count_q <= count_d;
        fires_q <= fires_d;
        tmr_q   <= tmr_d;
        left_q  <= left_d;
        irq_q   <= irq_d;
      end
    end

    assign irq[g]  = irq_q;
    assign fire[g] = fire_ch;
  end

  assign interrupt = |irq;

  logic [CNT_W-1:0] total_q, total_d;
  logic [SUM_W-1:0] fire_sum, total_wide;

  always_comb begin
    fire_sum = '0;
    for (int i = 0; i < int'(NUM_CH); i++) fire_sum = fire_sum + SUM_W'(fire[i]);
    total_wide = SUM_W'(total_q) + fire_sum;
    if (total_wide > SUM_W'({CNT_W{1'b1}})) total_d = {CNT_W{1'b1}};
    else                                    total_d = total_wide[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign fired_total = total_q;

endmodule
